// File: rtl/sign_pkg.sv
// Shared types and constants for the sign-sensor frame packer.
// Optional macro SIGN_FRAME_TS_EN adds timestamp bytes to every frame.
package sign_pkg;

  typedef logic [7:0] byte_t;

  localparam int    NUM_CH_DEF   = 5;
  localparam int    SAMPLE_W_DEF = 12;
  localparam byte_t SYNC0_DEF    = 8'hAA;
  localparam byte_t SYNC1_DEF    = 8'h55;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SYNC0 = 4'd1;
  localparam logic [3:0] ST_SYNC1 = 4'd2;
  localparam logic [3:0] ST_SEQ   = 4'd3;
  localparam logic [3:0] ST_HI    = 4'd4;
  localparam logic [3:0] ST_LO    = 4'd5;
  localparam logic [3:0] ST_CSUM  = 4'd6;
`ifdef SIGN_FRAME_TS_EN
  localparam logic [3:0] ST_TS_HI = 4'd7;
  localparam logic [3:0] ST_TS_LO = 4'd8;
`endif

  function automatic int frame_len(input int num_ch);
`ifdef SIGN_FRAME_TS_EN
    return 3 + 2 * num_ch + 2 + 1;
`else
    return 3 + 2 * num_ch + 1;
`endif
  endfunction

endpackage

// File: rtl/sign_sample_buffer.sv
// Capture storage for one sample per channel, with fill mask, set-complete
// detection and the sticky bad-channel flag.
module sign_sample_buffer #(
  parameter int NUM_CH   = 5,
  parameter int SAMPLE_W = 12
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [2:0]                   wr_ch,
  input  logic [SAMPLE_W-1:0]          wr_data,
  input  logic                         clr_err,
  output logic [NUM_CH*SAMPLE_W-1:0]   cap_next,
  output logic                         set_done,
  output logic                         bad_ch
);

  logic [NUM_CH*SAMPLE_W-1:0] cap_q;
  logic [NUM_CH-1:0]          mask_q;
  logic [NUM_CH-1:0]          mask_next;
  logic                       ch_ok;

  assign ch_ok = (int'(wr_ch) < NUM_CH);

  // cap_next includes this cycle's write so the sender can copy a set on
  // the same edge the last sample arrives.
  always_comb begin
    cap_next  = cap_q;
    mask_next = mask_q;
    if (wr_en && ch_ok) begin
      cap_next[int'(wr_ch)*SAMPLE_W +: SAMPLE_W] = wr_data;
      mask_next[wr_ch] = 1'b1;
    end
  end

  assign set_done = &mask_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q  <= '0;
      mask_q <= '0;
      bad_ch <= 1'b0;
    end else begin
      cap_q  <= cap_next;
      mask_q <= set_done ? '0 : mask_next;
      if (wr_en && !ch_ok)
        bad_ch <= 1'b1;
      else if (clr_err)
        bad_ch <= 1'b0;
    end
  end

endmodule

// File: rtl/sign_frame_packer.sv
// Packs completed sample sets into SYNC/SEQ/data/CSUM byte frames for UART TX.
// Optional macro SIGN_FRAME_TS_EN inserts TS_HI/TS_LO before the checksum.
//
// state    | meaning
// IDLE     | no frame in flight
// SYNC0    | presenting first sync byte
// SYNC1    | presenting second sync byte
// SEQ      | presenting sequence number
// HI       | presenting upper bits of sample ch_idx
// LO       | presenting lower byte of sample ch_idx
// TS_HI/LO | presenting latched timestamp (optional)
// CSUM     | presenting checksum; a new set may start on its acceptance
module sign_frame_packer
  import sign_pkg::*;
#(
  parameter int    NUM_CH   = NUM_CH_DEF,
  parameter int    SAMPLE_W = SAMPLE_W_DEF,
  parameter byte_t SYNC0    = SYNC0_DEF,
  parameter byte_t SYNC1    = SYNC1_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2:0]          s_ch,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                frame_busy,
  output logic                overrun,
  output logic                bad_ch,
  input  logic                clr_err
);

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  logic [3:0]                 state;
  logic [2:0]                 ch_idx;
  byte_t                      seq;
  byte_t                      csum;
  logic [NUM_CH*SAMPLE_W-1:0] snd;
  logic [NUM_CH*SAMPLE_W-1:0] cap_next;
  logic                       set_done;
  logic                       accept;
  logic                       sender_free;
  logic                       start;
  logic [15:0]                samp16;

  sign_sample_buffer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (s_valid && s_ready),
    .wr_ch    (s_ch),
    .wr_data  (s_data),
    .clr_err  (clr_err),
    .cap_next (cap_next),
    .set_done (set_done),
    .bad_ch   (bad_ch)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_ready <= 1'b0;
    else          s_ready <= 1'b1;
  end

  assign tx_valid    = (state != ST_IDLE);
  assign frame_busy  = (state != ST_IDLE);
  assign accept      = tx_valid && tx_ready;
  assign sender_free = (state == ST_IDLE) || (state == ST_CSUM && accept);
  assign start       = set_done && sender_free;
  assign samp16      = 16'(snd[int'(ch_idx)*SAMPLE_W +: SAMPLE_W]);

`ifdef SIGN_FRAME_TS_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_lat;

  // Latched only when a frame actually starts, so a dropped set cannot
  // disturb the timestamp of the frame still draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (start) ts_lat <= ts_cnt;
    end
  end
`endif

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_SYNC0: tx_data = SYNC0;
      ST_SYNC1: tx_data = SYNC1;
      ST_SEQ:   tx_data = seq;
      ST_HI:    tx_data = samp16[15:8];
      ST_LO:    tx_data = samp16[7:0];
`ifdef SIGN_FRAME_TS_EN
      ST_TS_HI: tx_data = ts_lat[15:8];
      ST_TS_LO: tx_data = ts_lat[7:0];
`endif
      ST_CSUM:  tx_data = csum;
      default:  tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ch_idx  <= '0;
      seq     <= '0;
      csum    <= '0;
      snd     <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        case (state)
          ST_SYNC0: state <= ST_SYNC1;
          ST_SYNC1: state <= ST_SEQ;
          ST_SEQ: begin
            state  <= ST_HI;
            ch_idx <= '0;
            csum   <= csum + tx_data;
          end
          ST_HI: begin
            state <= ST_LO;
            csum  <= csum + tx_data;
          end
          ST_LO: begin
            csum <= csum + tx_data;
            if (ch_idx == LAST_CH) begin
`ifdef SIGN_FRAME_TS_EN
              state <= ST_TS_HI;
`else
              state <= ST_CSUM;
`endif
            end else begin
              ch_idx <= ch_idx + 3'd1;
              state  <= ST_HI;
            end
          end
`ifdef SIGN_FRAME_TS_EN
          ST_TS_HI: begin
            state <= ST_TS_LO;
            csum  <= csum + tx_data;
          end
          ST_TS_LO: begin
            state <= ST_CSUM;
            csum  <= csum + tx_data;
          end
`endif
          ST_CSUM: begin
            state <= ST_IDLE;
            seq   <= seq + 8'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end

      // A start overrides the CSUM->IDLE step for back-to-back frames.
      if (start) begin
        state  <= ST_SYNC0;
        snd    <= cap_next;
        csum   <= '0;
        ch_idx <= '0;
      end

      if (set_done && !sender_free)
        overrun <= 1'b1;
      else if (clr_err)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_frame_packer.sv
// Scoreboard bench for sign_frame_packer (default build, SIGN_FRAME_TS_EN undefined).
`timescale 1ns/1ps
module tb_sign_frame_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [2:0]  s_ch = '0;
  logic [11:0] s_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        frame_busy;
  logic        overrun;
  logic        bad_ch;
  logic        clr_err = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sb[$];
  logic [11:0] cur[5];
  logic [7:0]  seq_m = 8'h00;
  logic        toggle_en = 1'b0;

  always #10 clk = ~clk;

  sign_frame_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_ch       (s_ch),
    .s_data     (s_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_busy (frame_busy),
    .overrun    (overrun),
    .bad_ch     (bad_ch),
    .clr_err    (clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input logic [2:0] ch, input logic [11:0] d);
    s_valid = 1'b1;
    s_ch    = ch;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_set();
    for (int i = 0; i < 5; i++) sample(3'(i), cur[i]);
  endtask

  task automatic push_frame(input logic [7:0] sq);
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    sb.push_back(8'hAA);
    sb.push_back(8'h55);
    sb.push_back(sq);
    cs = sq;
    for (int i = 0; i < 5; i++) begin
      hi = {4'h0, cur[i][11:8]};
      lo = cur[i][7:0];
      sb.push_back(hi);
      sb.push_back(lo);
      cs = cs + hi + lo;
    end
    sb.push_back(cs);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || frame_busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || frame_busy) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: pending=%0d busy=%0b required pending=0 busy=0", name, sb.size(), frame_busy);
      sb.delete();
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      tx_ready = ~tx_ready;
    end
  end

  // Monitor: every presented byte must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && tx_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h required=none at %0t", tx_data, $time);
      end else begin
        chk("frame_busy_in_frame", frame_busy, 1);
        if (tx_ready) begin
          chk("tx_byte", tx_data, sb[0]);
          void'(sb.pop_front());
        end else begin
          chk("tx_stall_hold", tx_data, sb[0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    #3;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_bad_ch", bad_ch, 0);
    chk("rst_s_ready", s_ready, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_after_release", s_ready, 1);

    // Directed frame with hand-computed bytes
    tx_ready = 1'b1;
    cur[0] = 12'h123; cur[1] = 12'h456; cur[2] = 12'h789; cur[3] = 12'hABC; cur[4] = 12'hFFF;
    foreach (sb[i]) sb.delete();
    sb.push_back(8'hAA); sb.push_back(8'h55); sb.push_back(8'h00);
    sb.push_back(8'h01); sb.push_back(8'h23); sb.push_back(8'h04); sb.push_back(8'h56);
    sb.push_back(8'h07); sb.push_back(8'h89); sb.push_back(8'h0A); sb.push_back(8'hBC);
    sb.push_back(8'h0F); sb.push_back(8'hFF); sb.push_back(8'hE2);
    for (int i = 0; i < 4; i++) sample(3'(i), cur[i]);
    chk("no_frame_before_complete", tx_valid, 0);
    sample(3'd4, cur[4]);
    chk("first_sync_valid", tx_valid, 1);
    chk("first_sync_data", tx_data, 32'hAA);
    wait_idle("frame0", 100);
    seq_m = 8'h01;

    // Same data, tx_ready toggling
    toggle_en = 1'b1;
    push_frame(seq_m);
    send_set();
    wait_idle("frame_stall", 200);
    toggle_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tx_ready = 1'b1;
    seq_m++;

    // Overrun: second set completes while first frame drains
    cur[0] = 12'h321; cur[1] = 12'h654; cur[2] = 12'h987; cur[3] = 12'hCBA; cur[4] = 12'h0F0;
    push_frame(seq_m);
    send_set();
    cur[0] = 12'h111; cur[1] = 12'h222; cur[2] = 12'h333; cur[3] = 12'h444; cur[4] = 12'h555;
    send_set();
    chk("overrun_set", overrun, 1);
    wait_idle("frame_overrun_a", 100);
    seq_m++;
    cur[0] = 12'h0AB; cur[1] = 12'h1CD; cur[2] = 12'h2EF; cur[3] = 12'h301; cur[4] = 12'h800;
    push_frame(seq_m);
    send_set();
    wait_idle("frame_after_overrun", 100);
    seq_m++;
    chk("overrun_sticky", overrun, 1);
    pulse_clr();
    chk("overrun_cleared", overrun, 0);

    // Bad channel mid-set, channel 2 written twice
    cur[0] = 12'h0A1; cur[1] = 12'h0B2; cur[2] = 12'h020; cur[3] = 12'h0C3; cur[4] = 12'h7D4;
    push_frame(seq_m);
    sample(3'd0, cur[0]);
    sample(3'd1, cur[1]);
    sample(3'd6, 12'h111);
    chk("bad_ch_set", bad_ch, 1);
    sample(3'd2, 12'h010);
    sample(3'd2, 12'h020);
    chk("no_frame_on_repeat", frame_busy, 0);
    sample(3'd3, cur[3]);
    sample(3'd4, cur[4]);
    wait_idle("frame_bad_ch", 100);
    seq_m++;
    pulse_clr();
    chk("bad_ch_cleared", bad_ch, 0);
    s_valid = 1'b1; s_ch = 3'd7; s_data = 12'h777; clr_err = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; clr_err = 1'b0;
    chk("bad_ch_set_wins", bad_ch, 1);
    pulse_clr();
    chk("bad_ch_cleared2", bad_ch, 0);

    // 256 back-to-back frames: each new set completes as CSUM is accepted
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 5; i++) cur[i] = 12'(k * 37 + i * 291 + 5);
      push_frame(seq_m);
      send_set();
      seq_m++;
      if (k < 255) repeat (9) begin @(posedge clk); #1; end
    end
    wait_idle("frame_seq_wrap", 200);
    chk("no_overrun_back_to_back", overrun, 0);

    // Reset during LO byte of ch2
    cur[0] = 12'h135; cur[1] = 12'h246; cur[2] = 12'h357; cur[3] = 12'h468; cur[4] = 12'h579;
    push_frame(seq_m);
    send_set();
    repeat (8) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_frame_busy", frame_busy, 0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    seq_m = 8'h00;
    @(posedge clk); #1;
    cur[0] = 12'h9AB; cur[1] = 12'h0CD; cur[2] = 12'h1EF; cur[3] = 12'h210; cur[4] = 12'h321;
    push_frame(seq_m);
    send_set();
    wait_idle("frame_after_reset", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
